// File: rtl/i2s_rx.sv
`timescale 1ns/1ps
// I2S receiver: synchronizes sck/ws/sd into clk, deserializes left/right words and presents
// stereo frames over a valid/ready handshake. Define I2S_RX_OVERRUN_EN to drop-and-flag instead of overwrite.
module i2s_rx #(
    parameter int AUDIO_DW    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable_i,
    input  logic                i2s_sck_i,
    input  logic                i2s_ws_i,
    input  logic                i2s_sd_i,
    output logic [AUDIO_DW-1:0] l_data_o,
    output logic [AUDIO_DW-1:0] r_data_o,
    output logic                frame_valid_o,
    input  logic                frame_ready_i,
    output logic                overrun_o,
    input  logic                clr_overrun_i
);

    localparam int CW = $clog2(AUDIO_DW + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(AUDIO_DW);

    localparam logic [1:0] ST_SYNC  = 2'd0;
    localparam logic [1:0] ST_LEFT  = 2'd1;
    localparam logic [1:0] ST_RIGHT = 2'd2;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] ws_sync;
    logic [SYNC_STAGES-1:0] sd_sync;
    logic                   sck_prev;
    logic                   ws_prev;
    logic                   sck_s;
    logic                   ws_s;
    logic                   sd_s;
    logic                   sck_rise;
    logic                   ws_edge;

    logic [1:0]             state;
    logic [AUDIO_DW-1:0]    shift_reg;
    logic [AUDIO_DW-1:0]    left_word;
    logic [AUDIO_DW-1:0]    cur_word;
    logic [CW-1:0]          bit_cnt;
    logic                   frame_done;
    logic                   handshake;
    logic                   load_frame;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign ws_s     = ws_sync[SYNC_STAGES-1];
    assign sd_s     = sd_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;
    assign ws_edge  = ws_s ^ ws_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_sync <= '0;
            ws_sync  <= '0;
            sd_sync  <= '0;
            sck_prev <= 1'b0;
            ws_prev  <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], i2s_sck_i};
            ws_sync  <= {ws_sync[SYNC_STAGES-2:0], i2s_ws_i};
            sd_sync  <= {sd_sync[SYNC_STAGES-2:0], i2s_sd_i};
            sck_prev <= sck_s;
            if (sck_rise) begin
                ws_prev <= ws_s;
            end
        end
    end

    // Word including the bit on the current rise; a saturated counter matches no position.
    always_comb begin
        cur_word = shift_reg;
        for (int i = 0; i < AUDIO_DW; i++) begin
            if (bit_cnt == CW'(AUDIO_DW - 1 - i)) begin
                cur_word[i] = sd_s;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_SYNC;
            shift_reg <= '0;
            bit_cnt   <= '0;
            left_word <= '0;
        end else if (!enable_i) begin
            state     <= ST_SYNC;
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (sck_rise) begin
            case (state)
                ST_SYNC: begin
                    if (ws_edge && !ws_s) begin
                        state     <= ST_LEFT;
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                    end
                end
                ST_LEFT, ST_RIGHT: begin
                    if (ws_edge) begin
                        if (state == ST_LEFT) begin
                            left_word <= cur_word;
                        end
                        state     <= (state == ST_LEFT) ? ST_RIGHT : ST_LEFT;
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                    end else begin
                        shift_reg <= cur_word;
                        if (bit_cnt < CNT_MAX) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_SYNC;
                end
            endcase
        end
    end

    assign frame_done = enable_i && sck_rise && (state == ST_RIGHT) && ws_edge && !ws_s;
    assign handshake  = frame_valid_o && frame_ready_i;

`ifdef I2S_RX_OVERRUN_EN
    logic overrun_q;

    assign load_frame = frame_done && (!frame_valid_o || frame_ready_i);
    assign overrun_o  = overrun_q;

    // Set takes priority over clear when both happen on one edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else if (frame_done && !load_frame) begin
            overrun_q <= 1'b1;
        end else if (clr_overrun_i) begin
            overrun_q <= 1'b0;
        end
    end
`else
    logic unused_clr;

    assign load_frame = frame_done;
    assign overrun_o  = 1'b0;
    assign unused_clr = clr_overrun_i;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            l_data_o      <= '0;
            r_data_o      <= '0;
            frame_valid_o <= 1'b0;
        end else if (load_frame) begin
            l_data_o      <= left_word;
            r_data_o      <= cur_word;
            frame_valid_o <= 1'b1;
        end else if (handshake) begin
            frame_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
`timescale 1ns/1ps
// Randomized bench for i2s_rx: an I2S word driver plus a word-level model of which
// stereo frames must appear; a monitor checks every handshaken frame against it.
module tb_i2s_rx;

    localparam int DW = 8;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          sck;
    logic          ws;
    logic          sd;
    logic [DW-1:0] l_data;
    logic [DW-1:0] r_data;
    logic          frame_valid;
    logic          frame_ready;
    logic          overrun;
    logic          clr_overrun;

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } frame_t;

    frame_t        exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            frames_seen = 0;
    int            frames_expected = 0;
    bit            in_sync = 1'b0;
    bit            have_left = 1'b0;
    logic [DW-1:0] left_pending;

    i2s_rx #(.AUDIO_DW(DW), .SYNC_STAGES(SS)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable_i      (enable),
        .i2s_sck_i     (sck),
        .i2s_ws_i      (ws),
        .i2s_sd_i      (sd),
        .l_data_o      (l_data),
        .r_data_o      (r_data),
        .frame_valid_o (frame_valid),
        .frame_ready_i (frame_ready),
        .overrun_o     (overrun),
        .clr_overrun_i (clr_overrun)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // MSB-aligned, zero-filled or truncated to DW bits.
    function automatic logic [DW-1:0] align_word(input logic [31:0] w, input int n);
        logic [31:0] v;
        if (n >= DW) v = w >> (n - DW);
        else         v = w << (DW - n);
        return v[DW-1:0];
    endfunction

    task automatic model_end_word(input bit ch, input logic [31:0] w, input int n);
        if (ch == 1'b0) begin
            if (in_sync) begin
                have_left    = 1'b1;
                left_pending = align_word(w, n);
            end
        end else begin
            if (in_sync && have_left) begin
                exp_q.push_back('{l: left_pending, r: align_word(w, n)});
                frames_expected++;
            end
            in_sync   = 1'b1;
            have_left = 1'b0;
        end
    endtask

    task automatic model_disrupt();
        in_sync   = 1'b0;
        have_left = 1'b0;
    endtask

    task automatic send_bit_low(input bit w, input bit d);
        @(negedge clk);
        sck = 1'b0;
        ws  = w;
        sd  = d;
        repeat (4) @(negedge clk);
        sck = 1'b1;
    endtask

    task automatic send_bit(input bit w, input bit d);
        send_bit_low(w, d);
        repeat (3) @(negedge clk);
    endtask

    // LSB goes out with ws already toggled; hold returns right at that final sck rise.
    task automatic apply_stimulus(input bit ch, input logic [31:0] w, input int n, input bit hold);
        for (int i = n - 1; i >= 1; i--) begin
            send_bit(ch, w[i]);
        end
        send_bit_low(~ch, w[0]);
        if (!hold) repeat (3) @(negedge clk);
        model_end_word(ch, w, n);
    endtask

    task automatic send_frame(input logic [31:0] l, input int ln, input logic [31:0] r, input int rn);
        apply_stimulus(1'b0, l, ln, 1'b0);
        apply_stimulus(1'b1, r, rn, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_l"}, l_data, 0);
        check_output({tag, "_r"}, r_data, 0);
        check_output({tag, "_valid"}, frame_valid, 0);
        check_output({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (frame_valid && frame_ready) begin
                frames_seen++;
                if (exp_q.size() == 0) begin
                    check_output("unexpected_frame", 1, 0);
                end else begin
                    check_output("frame_l", l_data, exp_q[0].l);
                    check_output("frame_r", r_data, exp_q[0].r);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] w;
        int          ln;
        int          rn;
        logic        exp_ovr;

        rst_n       = 1'b0;
        enable      = 1'b1;
        sck         = 1'b0;
        ws          = 1'b0;
        sd          = 1'b0;
        frame_ready = 1'b1;
        clr_overrun = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Stream opens on a right word that must never be reported.
        apply_stimulus(1'b1, 32'h11, 8, 1'b0);
        apply_stimulus(1'b0, 32'hA5, 8, 1'b0);
        apply_stimulus(1'b1, 32'h3C, 8, 1'b1);
        for (int k = 0; k <= SS + 1; k++) begin
            @(posedge clk);
            #1;
            check_output($sformatf("latency_edge%0d", k), frame_valid, (k == SS));
        end

        send_frame(32'b101101, 6, 32'b010011, 6);
        send_frame(32'h3FF, 10, 32'h155, 10);
        repeat (4) @(negedge clk);
        check_output("queue_drained_pre_bp", exp_q.size(), 0);

        @(negedge clk);
        frame_ready = 1'b0;
        send_frame(32'h01, 8, 32'h02, 8);
        send_frame(32'h03, 8, 32'h04, 8);
        repeat (4) @(negedge clk);
`ifdef I2S_RX_OVERRUN_EN
        void'(exp_q.pop_back());
        exp_ovr = 1'b1;
`else
        void'(exp_q.pop_front());
        exp_ovr = 1'b0;
`endif
        frames_expected--;
        #1;
        check_output("bp_valid", frame_valid, 1);
        check_output("bp_l", l_data, exp_q[0].l);
        check_output("bp_r", r_data, exp_q[0].r);
        check_output("bp_overrun", overrun, exp_ovr);
        @(negedge clk);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        #1;
        check_output("clr_overrun", overrun, 0);
        check_output("bp_valid_held", frame_valid, 1);
        @(negedge clk);
        frame_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_output("bp_valid_drop", frame_valid, 0);

        // Consumer becomes ready exactly on the edge the next frame completes.
        frame_ready = 1'b0;
        send_frame(32'h12, 8, 32'h34, 8);
        apply_stimulus(1'b0, 32'h56, 8, 1'b0);
        apply_stimulus(1'b1, 32'h78, 8, 1'b1);
        @(negedge clk);
        @(negedge clk);
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
        #1;
        check_output("simul_queue", exp_q.size(), 1);
        check_output("simul_valid", frame_valid, 1);
        check_output("simul_l", l_data, exp_q[0].l);
        check_output("simul_r", r_data, exp_q[0].r);
        check_output("simul_overrun", overrun, 0);
        @(negedge clk);
        frame_ready = 1'b1;

        // Reset in the middle of a right word.
        apply_stimulus(1'b0, 32'h77, 8, 1'b0);
        w = 32'h99;
        for (int i = 7; i >= 5; i--) send_bit(1'b1, w[i]);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_values("midreset");
        model_disrupt();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 4; i >= 1; i--) send_bit(1'b1, w[i]);
        send_bit(1'b0, w[0]);
        model_end_word(1'b1, w, 8);
        send_frame(32'h5A, 8, 32'hC3, 8);

        // Enable dropped in the middle of a right word.
        apply_stimulus(1'b0, 32'h66, 8, 1'b0);
        w = 32'hAA;
        for (int i = 7; i >= 6; i--) send_bit(1'b1, w[i]);
        enable = 1'b0;
        model_disrupt();
        for (int i = 5; i >= 3; i--) send_bit(1'b1, w[i]);
        enable = 1'b1;
        for (int i = 2; i >= 1; i--) send_bit(1'b1, w[i]);
        send_bit(1'b0, w[0]);
        model_end_word(1'b1, w, 8);
        send_frame(32'h5A, 8, 32'hC3, 8);

        for (int f = 0; f < 16; f++) begin
            ln = $urandom_range(2, 12);
            rn = $urandom_range(2, 12);
            send_frame($urandom & ((32'd1 << ln) - 1), ln, $urandom & ((32'd1 << rn) - 1), rn);
        end

        repeat (20) @(negedge clk);
        #1;
        check_output("final_queue_empty", exp_q.size(), 0);
        check_output("frame_count", frames_seen, frames_expected);
        check_output("final_overrun", overrun, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
